// File: rtl/lsq_queue.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lsq_queue : in-order load/store queue feeding the data memory stage.
// Revision  : 1.0
// -----------------------------------------------------------------------------
module lsq_queue #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 5,
    parameter int PREG_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_valid_i,
    input  logic              disp_is_store_i,
    input  logic [2:0]        disp_func3_i,
    input  logic [PREG_W-1:0] disp_pd_i,
    input  logic [TAG_W-1:0]  disp_rob_tag_i,
    input  logic [31:0]       disp_pc_i,
    output logic              lsq_full_o,
    input  logic              agu_valid_i,
    input  logic [TAG_W-1:0]  agu_rob_tag_i,
    input  logic [31:0]       agu_addr_i,
    input  logic [31:0]       agu_data_i,
    input  logic              commit_valid_i,
    input  logic [TAG_W-1:0]  commit_rob_tag_i,
    input  logic              flush_i,
    input  logic              mem_load_ready_i,
    output logic              store_wb_o,
    output logic [31:0]       st_addr_o,
    output logic [31:0]       st_data_o,
    output logic              st_sw_sh_o,
    output logic              load_mem_o,
    output logic [31:0]       ld_addr_o,
    output logic [2:0]        ld_func3_o,
    output logic [PREG_W-1:0] ld_pd_o,
    output logic [TAG_W-1:0]  ld_rob_tag_o,
    output logic [31:0]       ld_pc_o,
    output logic              lsq_err_o
);
    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0]   valid_q, valid_d, is_store_q, is_store_d;
    logic [DEPTH-1:0]   addr_ok_q, addr_ok_d, committed_q, committed_d;
    logic [31:0]        addr_q [DEPTH];
    logic [31:0]        data_q [DEPTH];
    logic [31:0]        pc_q   [DEPTH];
    logic [2:0]         func3_q[DEPTH];
    logic [PREG_W-1:0]  pd_q   [DEPTH];
    logic [TAG_W-1:0]   tag_q  [DEPTH];
    logic [c_PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [c_PTR_W:0]   count_q, count_d;

    logic               w_h_store, w_st_ok, w_ld_ok, w_f3_ok;
    logic               w_pop, w_pop_ok, w_push;
    logic [2:0]         w_h_f3;
    logic [c_PTR_W:0]   w_keep_n;
    logic [DEPTH-1:0]   w_agu_hit;

    assign w_h_store = is_store_q[head_q];
    assign w_h_f3    = func3_q[head_q];
    assign w_st_ok   = valid_q[head_q] & w_h_store & addr_ok_q[head_q] & committed_q[head_q];
    // A load at head is uncommitted, so a flush squashes it rather than issuing it.
    assign w_ld_ok   = valid_q[head_q] & ~w_h_store & addr_ok_q[head_q] & mem_load_ready_i & ~flush_i;
    assign w_f3_ok   = w_h_store ? (w_h_f3 == 3'b010 || w_h_f3 == 3'b001)
                                 : (w_h_f3 == 3'b010 || w_h_f3 == 3'b100);
    assign w_pop     = w_st_ok | w_ld_ok;
    assign w_pop_ok  = w_pop & w_f3_ok;
    assign w_push    = disp_valid_i & (count_q != c_FULL) & ~flush_i;

    // Length of the run of committed stores starting at head; these survive a flush.
    always_comb begin
        logic               run;
        logic [c_PTR_W-1:0] idx;
        run      = 1'b1;
        w_keep_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + c_PTR_W'(i);
            if (run && valid_q[idx] && is_store_q[idx] && committed_q[idx])
                w_keep_n = w_keep_n + (c_PTR_W+1)'(1);
            else
                run = 1'b0;
        end
    end

    always_comb begin
        valid_d     = valid_q;
        is_store_d  = is_store_q;
        addr_ok_d   = addr_ok_q;
        committed_d = committed_q;
        w_agu_hit   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_agu_hit[i] = agu_valid_i && valid_q[i] && (tag_q[i] == agu_rob_tag_i);
            if (w_agu_hit[i])
                addr_ok_d[i] = 1'b1;
            if (commit_valid_i && valid_q[i] && is_store_q[i] && (tag_q[i] == commit_rob_tag_i))
                committed_d[i] = 1'b1;
            if (flush_i && ({1'b0, c_PTR_W'(i) - head_q} >= w_keep_n))
                valid_d[i] = 1'b0;
        end
        if (w_pop)
            valid_d[head_q] = 1'b0;
        if (w_push) begin
            valid_d[tail_q]     = 1'b1;
            is_store_d[tail_q]  = disp_is_store_i;
            addr_ok_d[tail_q]   = 1'b0;
            committed_d[tail_q] = 1'b0;
        end
        head_d = head_q + c_PTR_W'(w_pop);
        if (flush_i) begin
            tail_d  = head_q + w_keep_n[c_PTR_W-1:0];
            count_d = w_keep_n - (c_PTR_W+1)'(w_pop);
        end else begin
            tail_d  = tail_q + c_PTR_W'(w_push);
            count_d = count_q + (c_PTR_W+1)'(w_push) - (c_PTR_W+1)'(w_pop);
        end
    end

    // Payload storage needs no reset: it is only read through a valid entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            func3_q[tail_q] <= disp_func3_i;
            pd_q[tail_q]    <= disp_pd_i;
            tag_q[tail_q]   <= disp_rob_tag_i;
            pc_q[tail_q]    <= disp_pc_i;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_agu_hit[i]) begin
                addr_q[i] <= agu_addr_i;
                data_q[i] <= agu_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            is_store_q   <= '0;
            addr_ok_q    <= '0;
            committed_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            lsq_full_o   <= 1'b0;
            store_wb_o   <= 1'b0;
            load_mem_o   <= 1'b0;
            lsq_err_o    <= 1'b0;
            st_addr_o    <= '0;
            st_data_o    <= '0;
            st_sw_sh_o   <= 1'b0;
            ld_addr_o    <= '0;
            ld_func3_o   <= '0;
            ld_pd_o      <= '0;
            ld_rob_tag_o <= '0;
            ld_pc_o      <= '0;
        end else begin
            valid_q     <= valid_d;
            is_store_q  <= is_store_d;
            addr_ok_q   <= addr_ok_d;
            committed_q <= committed_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            lsq_full_o  <= (count_d == c_FULL);
            store_wb_o  <= w_pop_ok & w_h_store;
            load_mem_o  <= w_pop_ok & ~w_h_store;
            lsq_err_o   <= w_pop & ~w_f3_ok;
            if (w_pop_ok && w_h_store) begin
                st_addr_o  <= addr_q[head_q];
                st_data_o  <= data_q[head_q];
                st_sw_sh_o <= (w_h_f3 == 3'b001);
            end
            if (w_pop_ok && !w_h_store) begin
                ld_addr_o    <= addr_q[head_q];
                ld_func3_o   <= w_h_f3;
                ld_pd_o      <= pd_q[head_q];
                ld_rob_tag_o <= tag_q[head_q];
                ld_pc_o      <= pc_q[head_q];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lsq_queue.sv
`default_nettype none
// tb_lsq_queue : directed self-checking bench for lsq_queue.
module tb_lsq_queue;
    localparam int TAG_W  = 5;
    localparam int PREG_W = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              disp_valid = 1'b0, disp_is_store = 1'b0;
    logic [2:0]        disp_func3 = '0;
    logic [PREG_W-1:0] disp_pd = '0;
    logic [TAG_W-1:0]  disp_rob_tag = '0;
    logic [31:0]       disp_pc = '0;
    logic              agu_valid = 1'b0;
    logic [TAG_W-1:0]  agu_rob_tag = '0;
    logic [31:0]       agu_addr = '0, agu_data = '0;
    logic              commit_valid = 1'b0;
    logic [TAG_W-1:0]  commit_rob_tag = '0;
    logic              flush = 1'b0, mem_load_ready = 1'b0;
    logic              lsq_full, store_wb, st_sw_sh, load_mem, lsq_err;
    logic [31:0]       st_addr, st_data, ld_addr, ld_pc;
    logic [2:0]        ld_func3;
    logic [PREG_W-1:0] ld_pd;
    logic [TAG_W-1:0]  ld_rob_tag;

    int n_assert = 0, n_fail = 0, n_st = 0, n_ld = 0, base_st = 0, base_ld = 0;

    always #5 clk = ~clk;

    lsq_queue #(.DEPTH(8), .TAG_W(TAG_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .reset(reset),
        .disp_valid_i(disp_valid), .disp_is_store_i(disp_is_store), .disp_func3_i(disp_func3),
        .disp_pd_i(disp_pd), .disp_rob_tag_i(disp_rob_tag), .disp_pc_i(disp_pc),
        .lsq_full_o(lsq_full),
        .agu_valid_i(agu_valid), .agu_rob_tag_i(agu_rob_tag), .agu_addr_i(agu_addr), .agu_data_i(agu_data),
        .commit_valid_i(commit_valid), .commit_rob_tag_i(commit_rob_tag),
        .flush_i(flush), .mem_load_ready_i(mem_load_ready),
        .store_wb_o(store_wb), .st_addr_o(st_addr), .st_data_o(st_data), .st_sw_sh_o(st_sw_sh),
        .load_mem_o(load_mem), .ld_addr_o(ld_addr), .ld_func3_o(ld_func3), .ld_pd_o(ld_pd),
        .ld_rob_tag_o(ld_rob_tag), .ld_pc_o(ld_pc), .lsq_err_o(lsq_err)
    );

    // Pulse counters, plus the rule that both pulses never coincide.
    always @(negedge clk) begin
        if (store_wb) n_st++;
        if (load_mem) n_ld++;
        if (store_wb || load_mem) begin
            n_assert++;
            assert (!(store_wb && load_mem)) else begin
                n_fail++;
                $error("FAIL both_pulses: observed store_wb=%0b load_mem=%0b expected not both", store_wb, load_mem);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic dispatch(input logic st, input logic [2:0] f3, input logic [PREG_W-1:0] pd,
                            input logic [TAG_W-1:0] tag, input logic [31:0] pc);
        disp_valid = 1'b1; disp_is_store = st; disp_func3 = f3;
        disp_pd = pd; disp_rob_tag = tag; disp_pc = pc;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic agu(input logic [TAG_W-1:0] tag, input logic [31:0] addr, input logic [31:0] data);
        agu_valid = 1'b1; agu_rob_tag = tag; agu_addr = addr; agu_data = data;
        tick();
        agu_valid = 1'b0;
    endtask

    task automatic commit(input logic [TAG_W-1:0] tag);
        commit_valid = 1'b1; commit_rob_tag = tag;
        tick();
        commit_valid = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_full", 32'(lsq_full), 0);
        chk("rst_store_wb", 32'(store_wb), 0);
        chk("rst_load_mem", 32'(load_mem), 0);
        chk("rst_err", 32'(lsq_err), 0);
        chk("rst_st_addr", st_addr, 0);
        chk("rst_ld_addr", ld_addr, 0);
        reset = 1'b0;
        tick();

        // single committed store
        dispatch(1'b1, 3'b010, '0, TAG_W'(3), 32'h1000);
        agu(TAG_W'(3), 32'h100, 32'hDEADBEEF);
        commit(TAG_W'(3));
        chk("t1_no_wb_at_commit_edge", 32'(store_wb), 0);
        tick();
        chk("t1_store_wb", 32'(store_wb), 1);
        chk("t1_st_addr", st_addr, 32'h100);
        chk("t1_st_data", st_data, 32'hDEADBEEF);
        chk("t1_sw_sh", 32'(st_sw_sh), 0);
        tick();
        chk("t1_one_cycle", 32'(store_wb), 0);
        chk("t1_payload_hold", st_addr, 32'h100);

        // load waits behind an uncommitted store
        mem_load_ready = 1'b1;
        dispatch(1'b1, 3'b010, '0, TAG_W'(1), 32'h2000);
        dispatch(1'b0, 3'b010, PREG_W'(9), TAG_W'(2), 32'h2004);
        agu(TAG_W'(1), 32'h200, 32'h11223344);
        agu(TAG_W'(2), 32'h300, 32'h0);
        base_ld = n_ld;
        repeat (3) tick();
        chk("t2_load_blocked", 32'(n_ld - base_ld), 0);
        commit(TAG_W'(1));
        chk("t2_no_wb_yet", 32'(store_wb), 0);
        tick();
        chk("t2_store_wb", 32'(store_wb), 1);
        chk("t2_st_addr", st_addr, 32'h200);
        chk("t2_no_ld_with_st", 32'(load_mem), 0);
        tick();
        chk("t2_load_mem", 32'(load_mem), 1);
        chk("t2_ld_pd", 32'(ld_pd), 9);
        chk("t2_ld_tag", 32'(ld_rob_tag), 2);
        chk("t2_ld_addr", ld_addr, 32'h300);
        chk("t2_ld_pc", ld_pc, 32'h2004);
        chk("t2_ld_func3", 32'(ld_func3), 2);
        tick();
        chk("t2_ld_one_cycle", 32'(load_mem), 0);

        // fill to full, overflow dispatch dropped, drain across the wrap
        mem_load_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dispatch(1'b0, 3'b010, PREG_W'(i), TAG_W'(10 + i), 32'h3000 + 32'(4 * i));
            if (i == 6) chk("t3_not_full_at_7", 32'(lsq_full), 0);
        end
        chk("t3_full_at_8", 32'(lsq_full), 1);
        dispatch(1'b0, 3'b010, '0, TAG_W'(18), 32'h3FFC);
        chk("t3_full_after_drop", 32'(lsq_full), 1);
        agu(TAG_W'(10), 32'h3100, 32'h0);
        mem_load_ready = 1'b1;
        tick();
        chk("t3_first_pop", 32'(load_mem), 1);
        chk("t3_first_tag", 32'(ld_rob_tag), 10);
        chk("t3_full_cleared", 32'(lsq_full), 0);
        mem_load_ready = 1'b0;
        for (int i = 11; i <= 18; i++) agu(TAG_W'(i), 32'h3000 + 32'(16 * i), 32'h0);
        mem_load_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("t3_drain_pulse", 32'(load_mem), 1);
            chk("t3_drain_tag", 32'(ld_rob_tag), 32'(11 + k));
        end
        chk("t3_last_addr", ld_addr, 32'h3110);
        tick();
        chk("t3_empty_a", 32'(load_mem), 0);
        tick();
        chk("t3_empty_b", 32'(load_mem), 0);

        // flush keeps only the committed head store
        dispatch(1'b1, 3'b010, '0, TAG_W'(4), 32'h4000);
        dispatch(1'b1, 3'b001, '0, TAG_W'(5), 32'h4004);
        dispatch(1'b0, 3'b010, PREG_W'(12), TAG_W'(6), 32'h4008);
        commit(TAG_W'(4));
        agu(TAG_W'(5), 32'h500, 32'hBBBB);
        agu(TAG_W'(6), 32'h600, 32'h0);
        flush = 1'b1;
        dispatch(1'b0, 3'b010, PREG_W'(1), TAG_W'(7), 32'h400C);
        flush = 1'b0;
        chk("t4_not_full_post_flush", 32'(lsq_full), 0);
        for (int i = 0; i < 6; i++) dispatch(1'b0, 3'b010, PREG_W'(20 + i), TAG_W'(20 + i), 32'h5000 + 32'(4 * i));
        chk("t4_count_7_not_full", 32'(lsq_full), 0);
        dispatch(1'b0, 3'b010, PREG_W'(26), TAG_W'(26), 32'h5018);
        chk("t4_count_8_full", 32'(lsq_full), 1);
        base_st = n_st; base_ld = n_ld;
        agu(TAG_W'(5), 32'h501, 32'h0);
        agu(TAG_W'(6), 32'h601, 32'h0);
        commit(TAG_W'(5));
        chk("t4_squashed_silent", 32'((n_st - base_st) + (n_ld - base_ld)), 0);
        agu(TAG_W'(4), 32'h400, 32'hAAAA);
        chk("t4_no_wb_yet", 32'(store_wb), 0);
        tick();
        chk("t4_store_wb", 32'(store_wb), 1);
        chk("t4_st_addr", st_addr, 32'h400);
        chk("t4_st_data", st_data, 32'hAAAA);
        chk("t4_full_after_pop", 32'(lsq_full), 0);
        mem_load_ready = 1'b0;
        for (int i = 20; i <= 26; i++) agu(TAG_W'(i), 32'h5100 + 32'(4 * i), 32'h0);
        mem_load_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("t4_drain_pulse", 32'(load_mem), 1);
            chk("t4_drain_tag", 32'(ld_rob_tag), 32'(20 + k));
        end
        tick();
        chk("t4_empty", 32'(load_mem), 0);
        chk("t4_total_st", 32'(n_st - base_st), 1);

        // halfword store
        dispatch(1'b1, 3'b001, '0, TAG_W'(30), 32'h6000);
        agu(TAG_W'(30), 32'h604, 32'h0000CAFE);
        commit(TAG_W'(30));
        tick();
        chk("t5_sh_wb", 32'(store_wb), 1);
        chk("t5_sh_flag", 32'(st_sw_sh), 1);
        chk("t5_sh_addr", st_addr, 32'h604);

        // load held at head by mem_load_ready
        mem_load_ready = 1'b0;
        dispatch(1'b0, 3'b100, PREG_W'(3), TAG_W'(8), 32'h7000);
        agu(TAG_W'(8), 32'h700, 32'h0);
        base_ld = n_ld;
        repeat (5) tick();
        chk("t6_stalled", 32'(n_ld - base_ld), 0);
        mem_load_ready = 1'b1;
        tick();
        chk("t6_load_mem", 32'(load_mem), 1);
        chk("t6_ld_func3", 32'(ld_func3), 32'h4);
        chk("t6_ld_pd", 32'(ld_pd), 3);
        chk("t6_ld_addr", ld_addr, 32'h700);
        tick();
        chk("t6_one_pulse", 32'(n_ld - base_ld), 1);

        // unsupported func3 pops with an error and no request
        dispatch(1'b0, 3'b000, PREG_W'(5), TAG_W'(9), 32'h7100);
        agu(TAG_W'(9), 32'h710, 32'h0);
        tick();
        chk("t7_err", 32'(lsq_err), 1);
        chk("t7_no_load", 32'(load_mem), 0);
        chk("t7_ld_addr_hold", ld_addr, 32'h700);
        tick();
        chk("t7_err_one_cycle", 32'(lsq_err), 0);

        // asynchronous reset with a store pulse in flight
        mem_load_ready = 1'b0;
        dispatch(1'b1, 3'b010, '0, TAG_W'(12), 32'h8000);
        for (int i = 13; i <= 15; i++) dispatch(1'b0, 3'b010, PREG_W'(i), TAG_W'(i), 32'h8000 + 32'(i));
        for (int i = 12; i <= 15; i++) agu(TAG_W'(i), 32'h800 + 32'(i), 32'h1234);
        commit(TAG_W'(12));
        reset = 1'b1;
        #1;
        chk("t8_store_wb", 32'(store_wb), 0);
        chk("t8_full", 32'(lsq_full), 0);
        chk("t8_st_addr", st_addr, 0);
        chk("t8_st_data", st_data, 0);
        chk("t8_ld_addr", ld_addr, 0);
        chk("t8_ld_pd", 32'(ld_pd), 0);
        base_st = n_st; base_ld = n_ld;
        tick();
        reset = 1'b0;
        mem_load_ready = 1'b1;
        repeat (5) tick();
        chk("t8_no_pulse_after", 32'((n_st - base_st) + (n_ld - base_ld)), 0);
        chk("t8_full_after", 32'(lsq_full), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lsq_queue.md
# lsq_queue

In-order load/store queue that sits directly upstream of the data memory stage. It allocates entries at dispatch and captures address and store data from the memory-address FU. Stores drain to memory only after ROB commit; loads issue from the queue head. Ordering is strict: a load never passes an older store, so no forwarding is required.

## Interface

Parameters:
- DEPTH, 8: number of entries; power of two.
- TAG_W, 5: ROB tag width.
- PREG_W, 7: physical destination register width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- disp_valid  in  1  allocate a new entry this cycle.
- disp_is_store  in  1  1 = store, 0 = load.
- disp_func3  in  3  load: 010 lw, 100 lbu; store: 010 sw, 001 sh.
- disp_pd  in  PREG_W  load destination physical register.
- disp_rob_tag  in  TAG_W  ROB tag of the instruction.
- disp_pc  in  32  instruction PC.
- lsq_full  out  1  count == DEPTH.
- agu_valid  in  1  address (and store data) ready.
- agu_rob_tag  in  TAG_W  tag to match.
- agu_addr  in  32  effective byte address.
- agu_data  in  32  store data (ps2); ignored for loads.
- commit_valid  in  1  ROB retiring an instruction.
- commit_rob_tag  in  TAG_W  retiring tag.
- flush  in  1  squash all uncommitted entries.
- mem_load_ready  in  1  memory accepts a load.
- store_wb  out  1  store write pulse.
- st_addr, st_data  out  32 each  store payload.
- st_sw_sh  out  1  0 = sw, 1 = sh.
- load_mem  out  1  load request pulse.
- ld_addr  out  32  load address.
- ld_func3  out  3  load width.
- ld_pd  out  PREG_W  load destination.
- ld_rob_tag  out  TAG_W  load tag.
- ld_pc  out  32  load PC.
- lsq_err  out  1  unsupported func3 popped.

## Operation

- Circular buffer with head, tail, and count (0..DEPTH). Pointers wrap modulo DEPTH.
- Each entry holds: valid, is_store, addr_ok, committed, addr, data, func3, pd, rob_tag, pc.
- Dispatch: if disp_valid && !lsq_full, write the entry at tail with addr_ok = committed = 0, then tail++. Dispatch while full is dropped; upstream must stall on lsq_full.
- AGU capture: every valid entry whose rob_tag == agu_rob_tag latches addr and data and sets addr_ok. An AGU tag that is not present is ignored.
- Commit: a valid store whose rob_tag matches sets committed. A commit matching a load is ignored.
- Pop decision uses registered entry state, at most one pop per cycle, head only:
  - Head store with addr_ok && committed: drive store_wb with its payload, then pop.
  - Head load with addr_ok && mem_load_ready: drive load_mem with its payload, then pop.
  - Head func3 not supported but eligible under the rules above: pop, pulse lsq_err, assert neither store_wb nor load_mem.
- store_wb and load_mem are never asserted in the same cycle.
- Flush: let N = the number of contiguous committed stores starting at head. All other entries are invalidated; tail = head + N; count = N.
  - Flush wins over same-cycle dispatch; the dispatch is dropped.
  - A same-cycle pop of a committed head store still happens.
- Simultaneous events in one cycle:
  - Dispatch and pop: count unchanged.
  - AGU and commit to the same entry: both applied.
  - AGU and pop eligibility: the new addr_ok is used from the next cycle only.

## Timing

- Reset values:
  - head = tail = count = 0; all entries invalid.
  - lsq_full, store_wb, load_mem, lsq_err = 0.
  - All payload outputs = 0.
- All outputs are registered. The pop decision is made in cycle t; the pulse and payload appear in cycle t+1 for exactly one cycle.
- Payload holds its last value when no pulse is active.
- Latency:
  - Store: commit registered at edge t, store_wb at t+1 at the earliest (addr_ok already set).
  - Load: reaches head with addr_ok and mem_load_ready high; load_mem follows 1 cycle later.
- Throughput: one pop per cycle. Back-to-back pulses are allowed.
- lsq_full reflects count after the current edge's updates.
- Reset asserted mid-operation clears everything asynchronously. Any pulse in flight is lost.

## Test plan

- Dispatch a store (sw, tag 3), AGU addr 0x100 data 0xDEADBEEF, commit tag 3 -> one store_wb, st_addr 0x100, st_data 0xDEADBEEF, st_sw_sh 0, the cycle after commit.
- Dispatch store tag 1, then load (lw, tag 2, pd 9); AGU both, no commit yet -> no load_mem. Commit tag 1 -> store_wb, then load_mem next cycle with ld_pd 9, ld_rob_tag 2.
- Fill 8 entries -> lsq_full 1; a 9th dispatch is dropped. Pop one -> lsq_full 0; pointers wrap correctly over 20 operations.
- Queue: committed store, uncommitted store, load; assert flush -> count 1, tail = head+1. The committed store still drains and the others never issue.
- Load at head with mem_load_ready 0 for 5 cycles -> no load_mem. Raise ready -> exactly one load_mem pulse.
- Assert reset while count = 4 and store_wb is pending -> all outputs 0 immediately; no pulse after reset releases.
